// File: rtl/rcg_ctrl_pkg.sv
// Shared types and defaults for the RCG divider-change sequencer.
package rcg_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StCheck  = 3'd1,
        StHold   = 3'd2,
        StGoHi   = 3'd3,
        StGoLo   = 3'd4,
        StSettle = 3'd5
    } state_e;

    localparam int unsigned DefHoldCyc    = 8;
    localparam int unsigned DefSettleCyc  = 16;
    localparam int unsigned DefTimeoutCyc = 256;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rcg_ctrl_seq_cnt.sv
// Loadable, clearable, saturating up-counter with a terminal-count flag.
module rcg_ctrl_seq_cnt #(
    parameter int unsigned W = 9
) (
    input  logic         clk_i,
    input  logic         grst_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (grst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/rcg_ctrl_div_seq.sv
// Divider-ratio change sequencer: gates RCCs, runs the 4-phase go/ack handshake
// with the clock-controller core, then releases the gates after a settle period.
module rcg_ctrl_div_seq
    import rcg_ctrl_pkg::*;
#(
    parameter int unsigned          DIV_WIDTH   = 16,
    parameter int unsigned          RCC_NUM     = 1,
    parameter logic [RCC_NUM-1:0]   HOLD_MASK   = {RCC_NUM{1'b1}},
    parameter logic [DIV_WIDTH-1:0] RST_RATIO   = 16'd2,
    parameter logic [DIV_WIDTH-1:0] MIN_RATIO   = 16'd1,
    parameter int unsigned          HOLD_CYC    = DefHoldCyc,
    parameter int unsigned          SETTLE_CYC  = DefSettleCyc,
    parameter int unsigned          TIMEOUT_CYC = DefTimeoutCyc
) (
    input  logic                 clk_in,
    input  logic                 grst,
    input  logic                 req_valid,
    input  logic [DIV_WIDTH-1:0] req_ratio,
    output logic                 req_ready,
    output logic [DIV_WIDTH-1:0] div_ratio,
    output logic                 divider_go,
    input  logic                 divider_go_ack,
    output logic [RCC_NUM-1:0]   rcc_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 err_range,
    output logic                 err_timeout,
    output logic [DIV_WIDTH-1:0] cur_ratio
);

    localparam int unsigned MaxHs  = (HOLD_CYC > SETTLE_CYC) ? HOLD_CYC : SETTLE_CYC;
    localparam int unsigned MaxCyc = (TIMEOUT_CYC > MaxHs) ? TIMEOUT_CYC : MaxHs;
    localparam int unsigned CntW   = cnt_width(MaxCyc);

    localparam logic [CntW-1:0] HoldTerm    = CntW'(HOLD_CYC - 1);
    localparam logic [CntW-1:0] SettleTerm  = CntW'(SETTLE_CYC - 1);
    localparam logic [CntW-1:0] TimeoutTerm = CntW'(TIMEOUT_CYC - 1);

    state_e                 state_d, state_q;
    logic [DIV_WIDTH-1:0]   new_ratio_d, new_ratio_q;
    logic [DIV_WIDTH-1:0]   div_ratio_d, div_ratio_q;
    logic [DIV_WIDTH-1:0]   cur_ratio_d, cur_ratio_q;
    logic [RCC_NUM-1:0]     rcc_hold_d, rcc_hold_q;
    logic                   go_d, go_q;
    logic                   done_d, done_q;
    logic                   err_range_d, err_range_q;
    logic                   err_timeout_d, err_timeout_q;

    logic                   cnt_clr, cnt_en, cnt_tc;
    logic [CntW-1:0]        cnt_term;

    // One counter serves every timed state; it restarts on each state change.
    assign cnt_clr = (state_d != state_q);
    assign cnt_en  = (state_q == StHold) || (state_q == StGoHi) ||
                     (state_q == StGoLo) || (state_q == StSettle);

    always_comb begin
        cnt_term = TimeoutTerm;
        unique case (state_q)
            StHold:   cnt_term = HoldTerm;
            StSettle: cnt_term = SettleTerm;
            default:  cnt_term = TimeoutTerm;
        endcase
    end

    rcg_ctrl_seq_cnt #(
        .W (CntW)
    ) u_seq_cnt (
        .clk_i      (clk_in),
        .grst_i     (grst),
        .clr_i      (cnt_clr),
        .load_i     (1'b0),
        .load_val_i ({CntW{1'b0}}),
        .en_i       (cnt_en),
        .term_i     (cnt_term),
        .tc_o       (cnt_tc)
    );

    always_comb begin
        state_d       = state_q;
        new_ratio_d   = new_ratio_q;
        div_ratio_d   = div_ratio_q;
        cur_ratio_d   = cur_ratio_q;
        rcc_hold_d    = rcc_hold_q;
        go_d          = go_q;
        done_d        = 1'b0;
        err_range_d   = 1'b0;
        err_timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    new_ratio_d = req_ratio;
                    state_d     = StCheck;
                end
            end
            StCheck: begin
                if (new_ratio_q < MIN_RATIO) begin
                    err_range_d = 1'b1;
                    state_d     = StIdle;
                end else if (new_ratio_q == cur_ratio_q) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    rcc_hold_d = HOLD_MASK;
                    state_d    = StHold;
                end
            end
            StHold: begin
                if (cnt_tc) begin
                    div_ratio_d = new_ratio_q;
                    go_d        = 1'b1;
                    state_d     = StGoHi;
                end
            end
            StGoHi: begin
                if (divider_go_ack) begin
                    go_d    = 1'b0;
                    state_d = StGoLo;
                end else if (cnt_tc) begin
                    go_d          = 1'b0;
                    div_ratio_d   = cur_ratio_q;
                    rcc_hold_d    = '0;
                    err_timeout_d = 1'b1;
                    state_d       = StIdle;
                end
            end
            StGoLo: begin
                if (!divider_go_ack) begin
                    state_d = StSettle;
                end else if (cnt_tc) begin
                    go_d          = 1'b0;
                    div_ratio_d   = cur_ratio_q;
                    rcc_hold_d    = '0;
                    err_timeout_d = 1'b1;
                    state_d       = StIdle;
                end
            end
            StSettle: begin
                if (cnt_tc) begin
                    rcc_hold_d  = '0;
                    cur_ratio_d = new_ratio_q;
                    done_d      = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (grst) begin
            state_q       <= StIdle;
            new_ratio_q   <= RST_RATIO;
            div_ratio_q   <= RST_RATIO;
            cur_ratio_q   <= RST_RATIO;
            rcc_hold_q    <= '0;
            go_q          <= 1'b0;
            done_q        <= 1'b0;
            err_range_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            new_ratio_q   <= new_ratio_d;
            div_ratio_q   <= div_ratio_d;
            cur_ratio_q   <= cur_ratio_d;
            rcc_hold_q    <= rcc_hold_d;
            go_q          <= go_d;
            done_q        <= done_d;
            err_range_q   <= err_range_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign req_ready   = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign div_ratio   = div_ratio_q;
    assign cur_ratio   = cur_ratio_q;
    assign rcc_hold    = rcc_hold_q;
    assign divider_go  = go_q;
    assign done        = done_q;
    assign err_range   = err_range_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_rcg_ctrl_div_seq.sv
// Bench for rcg_ctrl_div_seq: per-request timeline model derived from the phase lengths.
module tb_rcg_ctrl_div_seq;

    localparam int          HoldCyc    = 8;
    localparam int          SettleCyc  = 16;
    localparam int          TimeoutCyc = 256;
    localparam logic [15:0] RstRatio   = 16'd2;
    localparam logic [15:0] MinRatio   = 16'd1;

    logic        clk_in = 1'b0;
    logic        grst;
    logic        req_valid;
    logic [15:0] req_ratio;
    logic        req_ready;
    logic [15:0] div_ratio;
    logic        divider_go;
    logic        divider_go_ack;
    logic [0:0]  rcc_hold;
    logic        busy;
    logic        done;
    logic        err_range;
    logic        err_timeout;
    logic [15:0] cur_ratio;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] cur_m;

    always #5 clk_in = ~clk_in;

    rcg_ctrl_div_seq dut (
        .clk_in         (clk_in),
        .grst           (grst),
        .req_valid      (req_valid),
        .req_ratio      (req_ratio),
        .req_ready      (req_ready),
        .div_ratio      (div_ratio),
        .divider_go     (divider_go),
        .divider_go_ack (divider_go_ack),
        .rcc_hold       (rcc_hold),
        .busy           (busy),
        .done           (done),
        .err_range      (err_range),
        .err_timeout    (err_timeout),
        .cur_ratio      (cur_ratio)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph, input int k, input logic go_e, input logic hold_e,
                             input logic busy_e, input logic done_e, input logic er_e,
                             input logic et_e, input logic [15:0] div_e, input logic [15:0] cur_e);
        chk($sformatf("%s k=%0d divider_go", ph, k), 32'(divider_go), 32'(go_e));
        chk($sformatf("%s k=%0d rcc_hold", ph, k), 32'(rcc_hold), 32'(hold_e));
        chk($sformatf("%s k=%0d busy", ph, k), 32'(busy), 32'(busy_e));
        chk($sformatf("%s k=%0d req_ready", ph, k), 32'(req_ready), 32'(!busy_e));
        chk($sformatf("%s k=%0d done", ph, k), 32'(done), 32'(done_e));
        chk($sformatf("%s k=%0d err_range", ph, k), 32'(err_range), 32'(er_e));
        chk($sformatf("%s k=%0d err_timeout", ph, k), 32'(err_timeout), 32'(et_e));
        chk($sformatf("%s k=%0d div_ratio", ph, k), 32'(div_ratio), 32'(div_e));
        chk($sformatf("%s k=%0d cur_ratio", ph, k), 32'(cur_ratio), 32'(cur_e));
    endtask

    task automatic idle_cycles(input int n, input logic ack_val);
        divider_go_ack = ack_val;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            check_all("idle", i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cur_m, cur_m);
        end
        divider_go_ack = 1'b0;
    endtask

    // k counts clock edges after the accepting edge. d: ack rises d cycles after go is
    // seen (-1 = already high on entry, >=TimeoutCyc = never). f: ack falls f cycles
    // after go drops (>=TimeoutCyc = never). ev: 0 done, 1 range error, 2 timeout.
    task automatic run_req(input string ph, input logic [15:0] r, input int d, input int f,
                           input bit hold_next, input logic [15:0] nxt, input int abort_k);
        int          go_k, lo_k, end_k, ev;
        bit          change;
        logic [15:0] old;
        logic        go_e, hold_e;
        logic [15:0] div_e, cur_e;

        old    = cur_m;
        change = 1'b0;
        go_k   = 1 + HoldCyc;
        lo_k   = 0;
        if (r < MinRatio) begin
            ev    = 1;
            end_k = 1;
        end else if (r == old) begin
            ev    = 0;
            end_k = 1;
        end else begin
            change = 1'b1;
            if (d >= TimeoutCyc) begin
                ev    = 2;
                end_k = go_k + TimeoutCyc;
            end else begin
                lo_k = go_k + ((d < 0) ? 0 : d) + 1;
                if (f >= TimeoutCyc) begin
                    ev    = 2;
                    end_k = lo_k + TimeoutCyc;
                end else begin
                    ev    = 0;
                    end_k = lo_k + f + 1 + SettleCyc;
                end
            end
        end

        req_valid = 1'b1;
        req_ratio = r;
        for (int k = 0; k <= end_k; k++) begin
            @(negedge clk_in);
            go_e   = change && (k >= go_k) && ((lo_k != 0) ? (k < lo_k) : (k < end_k));
            hold_e = change && (k >= 1) && (k < end_k);
            div_e  = (change && (k >= go_k) && ((k < end_k) || (ev == 0))) ? r : old;
            cur_e  = ((k == end_k) && (ev == 0)) ? r : old;
            check_all(ph, k, go_e, hold_e, k < end_k, (k == end_k) && (ev == 0),
                      (k == end_k) && (ev == 1), (k == end_k) && (ev == 2), div_e, cur_e);
            if (abort_k >= 0 && k == abort_k) begin
                grst = 1'b1;
                @(negedge clk_in);
                check_all({ph, "_abort"}, k + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                          RstRatio, RstRatio);
                grst           = 1'b0;
                req_valid      = 1'b0;
                divider_go_ack = 1'b0;
                cur_m          = RstRatio;
                return;
            end
            if (k == 0) begin
                req_valid = hold_next;
                req_ratio = hold_next ? nxt : 16'($urandom);
            end
            if (change && k < end_k) begin
                divider_go_ack = (d < TimeoutCyc) && (k >= go_k + d) &&
                                 !((f < TimeoutCyc) && (lo_k != 0) && (k >= lo_k + f));
            end else begin
                divider_go_ack = 1'b0;
            end
        end
        if (ev == 0) cur_m = r;
    endtask

    initial begin
        grst           = 1'b1;
        req_valid      = 1'b0;
        req_ratio      = 16'd0;
        divider_go_ack = 1'b0;
        cur_m          = RstRatio;
        repeat (3) @(negedge clk_in);
        check_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RstRatio, RstRatio);
        grst = 1'b0;
        @(negedge clk_in);
        check_all("post_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RstRatio, RstRatio);

        run_req("range0", 16'd0, 0, 0, 1'b0, 16'd0, -1);
        run_req("same2", 16'd2, 0, 0, 1'b0, 16'd0, -1);
        run_req("to_hi", 16'd9, 300, 0, 1'b0, 16'd0, -1);
        run_req("to_lo", 16'd9, 1, 300, 1'b0, 16'd0, -1);
        idle_cycles(3, 1'b1);
        run_req("main4", 16'd4, 2, 0, 1'b0, 16'd0, -1);
        run_req("abort", 16'd7, 300, 0, 1'b0, 16'd0, 10);
        idle_cycles(3, 1'b0);
        run_req("held_a", 16'd5, 2, 1, 1'b1, 16'd7, -1);
        run_req("held_b", 16'd7, -1, 0, 1'b0, 16'd0, -1);
        run_req("ack_pre", 16'd3, -1, 2, 1'b0, 16'd0, -1);

        for (int i = 0; i < 16; i++) begin
            run_req($sformatf("rnd%0d", i), 16'($urandom_range(0, 6)),
                    int'($urandom_range(0, 5)) - 1, int'($urandom_range(0, 4)),
                    1'b0, 16'd0, -1);
            idle_cycles(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rcg_ctrl_div_seq.md
Name: rcg_ctrl_div_seq

Overview:
- Sequencer directly upstream of the RCG clock-controller core. It accepts software divider-ratio change requests and drives the core's div_ratio / divider_go inputs.
- It gates the selected RCC outputs through the core's force_rcc_off inputs before each change and releases them after a settle period.
- It runs a 4-phase divider_go/divider_go_ack handshake with timeout.
- It reports busy, done and error status, plus the currently applied ratio.

Parameters:
- DIV_WIDTH, 16, width of the divider ratio.
- RCC_NUM, 1, number of RCC outputs controlled.
- HOLD_MASK, {RCC_NUM{1'b1}}, RCCs gated (force_rcc_off) during a change.
- RST_RATIO, 16'd2, ratio driven out of reset.
- MIN_RATIO, 16'd1, smallest legal ratio.
- HOLD_CYC, 8, cycles of gating before divider_go.
- SETTLE_CYC, 16, cycles of gating after the handshake completes.
- TIMEOUT_CYC, 256, max cycles waiting on each handshake phase.

Ports:
- clk_in  in  1  sequencer clock (same clock as the core's clk_in).
- grst  in  1  synchronous, active-high reset.
- req_valid  in  1  change request.
- req_ratio  in  DIV_WIDTH  requested ratio; sampled when req_valid && req_ready.
- req_ready  out  1  high only in IDLE.
- div_ratio  out  DIV_WIDTH  ratio presented to the core.
- divider_go  out  1  handshake request to the core.
- divider_go_ack  in  1  handshake acknowledge from the core.
- rcc_hold  out  RCC_NUM  drives the core's force_rcc_off.
- busy  out  1  state != IDLE.
- done  out  1  1-cycle pulse; change applied.
- err_range  out  1  1-cycle pulse; request rejected.
- err_timeout  out  1  1-cycle pulse; handshake timed out.
- cur_ratio  out  DIV_WIDTH  last successfully applied ratio.

Behaviour:
- Interface fixed: one clock, clk_in. grst is synchronous and active-high; all flops are reset only on a clk_in edge with grst=1.
- Reset values:
  - div_ratio = cur_ratio = RST_RATIO.
  - divider_go, rcc_hold, busy, done, err_range, err_timeout all 0.
  - req_ready = 1 in the cycle after reset releases.
  - State = IDLE; counters = 0.
- grst mid-sequence: immediate return to reset values.
  - divider_go drops and rcc_hold releases in the same cycle.
  - No done or error pulse is generated.
- States: IDLE, CHECK, HOLD, GO_HI, GO_LO, SETTLE.
- IDLE: on req_valid, latch req_ratio into new_ratio and go to CHECK. Requests are sampled only in IDLE; req_valid while busy is ignored and not queued.
- CHECK (1 cycle), first matching rule applies:
  1. new_ratio < MIN_RATIO -> err_range pulse, back to IDLE, no gating.
  2. new_ratio == cur_ratio -> done pulse, back to IDLE, no gating, no handshake.
  3. Otherwise -> HOLD, with rcc_hold = HOLD_MASK.
- HOLD:
  - Counter counts 0..HOLD_CYC-1, then go to GO_HI.
  - On entering GO_HI, div_ratio = new_ratio and divider_go = 1 in the same cycle.
  - div_ratio is stable for at least 1 cycle before it is sampled with go high; go and ratio change together, and the core must sample the ratio on go.
- GO_HI:
  - Hold divider_go = 1 until divider_go_ack = 1, then divider_go = 0 and go to GO_LO.
  - If the count reaches TIMEOUT_CYC: timeout.
- GO_LO:
  - Wait for divider_go_ack = 0, then go to SETTLE.
  - If the count reaches TIMEOUT_CYC: timeout.
- SETTLE:
  - Count SETTLE_CYC cycles, then in the same cycle: rcc_hold = 0, cur_ratio = new_ratio, done pulse, IDLE.
- Timeout (GO_HI or GO_LO), in the same cycle:
  - divider_go = 0, div_ratio restored to cur_ratio, rcc_hold = 0.
  - err_timeout pulse; go to IDLE. cur_ratio is unchanged.
- Timeout counter: cleared on entry to GO_HI and to GO_LO. Width is $clog2(TIMEOUT_CYC+1); it saturates and does not wrap.
- Ack already high on entry to GO_HI is accepted in the first cycle, giving minimum GO_HI length 1.
- Ack high in IDLE/HOLD/SETTLE is ignored.
- Minimum latency, request accepted to done: 1 (CHECK) + HOLD_CYC + 1 (GO_HI) + 1 (GO_LO) + SETTLE_CYC cycles.
- done, err_range and err_timeout are mutually exclusive per request; exactly one pulses per accepted request.
- Widths: all ratio comparisons are unsigned, DIV_WIDTH bits.

Decomposition:
- Package rcg_ctrl_pkg holds:
  - state enum encoding (3-bit: IDLE=0, CHECK=1, HOLD=2, GO_HI=3, GO_LO=4, SETTLE=5);
  - the default HOLD/SETTLE/TIMEOUT constants;
  - the counter-width function.
- One natural sub-module: rcg_ctrl_seq_cnt, a loadable, saturating, clearable counter with terminal-count flag. It is instanced once and shared by HOLD, GO_HI, GO_LO and SETTLE, with a per-state terminal value.

Test Plan:
- Reset, then req_ratio=4, ack returned 2 cycles after go.
  - Expect rcc_hold=1 for 8 HOLD cycles before go, then through SETTLE.
  - Expect div_ratio=4 with go.
  - Expect done pulse 8+1+3+1+16 cycles after acceptance; cur_ratio=4.
- req_ratio=0 with MIN_RATIO=1 -> err_range after 1 cycle; rcc_hold never asserts; div_ratio stays 2.
- req_ratio=2 at reset (equal to cur_ratio) -> done after 1 cycle; divider_go and rcc_hold never assert.
- Ack held low -> err_timeout 256 cycles after go rises; divider_go=0, div_ratio=2, rcc_hold=0, cur_ratio=2.
- Ack rises but never falls -> err_timeout 256 cycles into GO_LO; cur_ratio unchanged.
- grst asserted in GO_HI with go=1 -> next cycle go=0, rcc_hold=0, div_ratio=2, req_ready=1, no pulses.
- req_valid held high during busy with a different ratio -> ignored until IDLE; exactly one done per accepted request.
